// File: rtl/write_address_ctrl.sv
// Write-side address controller for a synchronous FIFO.
// Holds the write pointer (with an extra wrap bit), issues registered memory
// write strobes, and derives occupancy, full/almost-full and a sticky
// overflow flag against the read pointer from the same clock domain.
module write_address_ctrl #(
    parameter int MEMORY_DEPTH = 8,
    parameter int ADDRESS_SIZE = 3,
    parameter int DATA_WIDTH   = 8,
    parameter int AF_THRESHOLD = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_req,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [ADDRESS_SIZE:0]   r_ptr,
    input  logic                    clr_ovf,
    output logic [ADDRESS_SIZE:0]   w_ptr,
    output logic                    mem_we,
    output logic [ADDRESS_SIZE-1:0] mem_waddr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic                    full,
    output logic                    almost_full,
    output logic [ADDRESS_SIZE:0]   level,
    output logic                    overflow
);

    // The pointer arithmetic below only works for a power-of-two depth.
    if (MEMORY_DEPTH != (1 << ADDRESS_SIZE)) begin : g_depth_check
        $error("write_address_ctrl: MEMORY_DEPTH must equal 2**ADDRESS_SIZE");
    end

    localparam logic [ADDRESS_SIZE:0] PTR_ONE = (ADDRESS_SIZE+1)'(1);
    localparam logic [ADDRESS_SIZE:0] AF_LVL  = (ADDRESS_SIZE+1)'(AF_THRESHOLD);

    logic accept;

    // Status flags: full when the pointers alias the same word but sit on
    // different laps; level is the lap-aware pointer difference.
    always_comb begin
        full        = (w_ptr[ADDRESS_SIZE] != r_ptr[ADDRESS_SIZE]) &&
                      (w_ptr[ADDRESS_SIZE-1:0] == r_ptr[ADDRESS_SIZE-1:0]);
        level       = w_ptr - r_ptr;
        almost_full = (level >= AF_LVL);
        accept      = wr_req & ~full;
    end

    // Write pointer and registered memory write port; address and data hold
    // when no write is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_ptr     <= '0;
            mem_we    <= 1'b0;
            mem_waddr <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= accept;
            if (accept) begin
                w_ptr     <= w_ptr + PTR_ONE;
                mem_waddr <= w_ptr[ADDRESS_SIZE-1:0];
                mem_wdata <= wr_data;
            end
        end
    end

    // Sticky overflow; a fresh overflow in the same cycle as a clear wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (wr_req && full) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_write_address_ctrl.sv
// Bench for write_address_ctrl: directed scenarios followed by random traffic.
// The driver computes expected post-edge outputs from a FIFO occupancy model
// and queues them; the monitor pops one entry after every edge and compares.
module tb_write_address_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_req = 1'b0;
    logic [7:0] wr_data = '0;
    logic [3:0] r_ptr = '0;
    logic       clr_ovf = 1'b0;
    logic [3:0] w_ptr;
    logic       mem_we;
    logic [2:0] mem_waddr;
    logic [7:0] mem_wdata;
    logic       full;
    logic       almost_full;
    logic [3:0] level;
    logic       overflow;

    write_address_ctrl #(
        .MEMORY_DEPTH(8), .ADDRESS_SIZE(3), .DATA_WIDTH(8), .AF_THRESHOLD(6)
    ) dut (
        .clk(clk), .rst(rst), .wr_req(wr_req), .wr_data(wr_data),
        .r_ptr(r_ptr), .clr_ovf(clr_ovf), .w_ptr(w_ptr), .mem_we(mem_we),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .full(full),
        .almost_full(almost_full), .level(level), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] w_ptr;
        logic       we;
        logic [2:0] waddr;
        logic [7:0] wdata;
        logic       ovf;
        logic       full;
        logic       af;
        logic [3:0] level;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: count of accepted writes modulo two laps, last written
    // word, and the sticky overflow state.
    int         m_w = 0;
    logic [2:0] m_waddr = '0;
    logic [7:0] m_wdata = '0;
    logic       m_ovf = 1'b0;
    int         m_rp = 0;

    task automatic step(input logic r, input logic w, input logic [7:0] d,
                        input int rpv, input logic c);
        int   occ;
        logic was_full;
        exp_t e;
        @(negedge clk);
        rst = r; wr_req = w; wr_data = d; r_ptr = 4'(rpv); clr_ovf = c;
        m_rp = rpv % 16;
        occ = (m_w - m_rp + 16) % 16;
        was_full = (occ == 8);
        e.we = 1'b0;
        if (r) begin
            m_w = 0; m_waddr = '0; m_wdata = '0; m_ovf = 1'b0;
        end else begin
            if (w && !was_full) begin
                e.we    = 1'b1;
                m_waddr = 3'(m_w % 8);
                m_wdata = d;
                m_w     = (m_w + 1) % 16;
            end
            if (w && was_full) m_ovf = 1'b1;
            else if (c)        m_ovf = 1'b0;
        end
        occ     = (m_w - m_rp + 16) % 16;
        e.w_ptr = 4'(m_w);
        e.waddr = m_waddr;
        e.wdata = m_wdata;
        e.ovf   = m_ovf;
        e.level = 4'(occ);
        e.full  = (occ == 8);
        e.af    = (occ >= 6);
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input int act, input int req);
        if (act != req) begin
            miscompares++;
            $display("FAIL %s at vector %0d: got %0d, expected %0d", name, vectors, act, req);
        end
    endtask

    // Monitor: after each rising edge compare the DUT against the oldest entry.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                chk("w_ptr",       int'(w_ptr),       int'(e.w_ptr));
                chk("mem_we",      int'(mem_we),      int'(e.we));
                chk("mem_waddr",   int'(mem_waddr),   int'(e.waddr));
                chk("mem_wdata",   int'(mem_wdata),   int'(e.wdata));
                chk("overflow",    int'(overflow),    int'(e.ovf));
                chk("full",        int'(full),        int'(e.full));
                chk("almost_full", int'(almost_full), int'(e.af));
                chk("level",       int'(level),       int'(e.level));
            end
        end
    end

    initial begin
        int rp;
        int occ;
        logic r, w, c;
        // Reset with a pending write request.
        step(1, 1, 8'h33, 0, 0);
        step(1, 1, 8'h34, 0, 0);
        // Fill from empty: addresses 0..7, full after the eighth.
        for (int i = 0; i < 8; i++) step(0, 1, 8'(8'h10 + i), 0, 0);
        // Write while full: rejected, overflow sets and holds until cleared.
        step(0, 1, 8'hAA, 0, 0);
        step(0, 0, 8'h00, 0, 0);
        step(0, 0, 8'h00, 0, 1);
        // Overflow and clear in the same cycle: set wins.
        step(0, 1, 8'hBB, 0, 1);
        step(0, 0, 8'h00, 0, 1);
        // Read side caught up (r_ptr=8) then writes around the aliasing point.
        step(0, 1, 8'h40, 8, 0);
        step(0, 1, 8'h41, 1, 0);
        step(0, 1, 8'h42, 2, 0);
        // Walk the write pointer to 15, then wrap it to 0.
        while (m_w != 15) step(0, 1, 8'(m_w), (m_w + 15) % 16, 0);
        step(0, 1, 8'h5A, 14, 0);
        // Reset mid-burst.
        step(1, 0, 8'h00, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 8'(8'h60 + i), 0, 0);
        step(1, 1, 8'h77, 0, 0);
        // Random traffic with a consistent read side.
        rp = 0;
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 99) < 1);
            w = ($urandom_range(0, 99) < 70);
            c = ($urandom_range(0, 99) < 10);
            if (r) begin
                rp = 0;
            end else begin
                occ = (m_w - rp + 16) % 16;
                if (occ > 0 && $urandom_range(0, 1) == 1) rp = (rp + 1) % 16;
            end
            step(r, w, 8'($urandom), rp, c);
        end
        @(negedge clk);
        wr_req = 1'b0; rst = 1'b0; clr_ovf = 1'b0;
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
